// File: rtl/dmem_io_pkg.sv
// Shared constants and address decode for the CPU data-memory responder.
// Addresses with bit 15 set map to I/O registers, the rest map to word RAM.
package dmem_io_pkg;

    localparam int IO_SEL_BIT = 15;

    localparam logic [15:0] ADDR_DISP   = 16'h8000;
    localparam logic [15:0] ADDR_SW     = 16'h8001;
    localparam logic [15:0] ADDR_TIMER  = 16'h8002;
    localparam logic [15:0] ADDR_STATUS = 16'h8003;

    localparam int ST_TIMER_EXP = 0;

    typedef enum logic [2:0] {
        SEL_RAM,
        SEL_DISP,
        SEL_SW,
        SEL_TIMER,
        SEL_STATUS,
        SEL_NONE
    } sel_e;

    function automatic sel_e addr_decode(input logic [15:0] a);
        sel_e s;
        if (!a[IO_SEL_BIT])        s = SEL_RAM;
        else if (a == ADDR_DISP)   s = SEL_DISP;
        else if (a == ADDR_SW)     s = SEL_SW;
        else if (a == ADDR_TIMER)  s = SEL_TIMER;
        else if (a == ADDR_STATUS) s = SEL_STATUS;
        else                       s = SEL_NONE;
        return s;
    endfunction

endpackage

// File: rtl/dmem_io_responder_if.sv
// CPU data-memory bus: the CPU is the master, the memory/I/O block the slave.
// Reads are combinational, so there is no handshake.
interface dmem_io_responder_if;

    logic [15:0] draddr;
    logic        dwrite;
    logic        dread;
    logic [15:0] dwdata;
    logic [15:0] drdata;

    modport master (
        output draddr,
        output dwrite,
        output dread,
        output dwdata,
        input  drdata
    );

    modport slave (
        input  draddr,
        input  dwrite,
        input  dread,
        input  dwdata,
        output drdata
    );

endinterface

// File: rtl/dmem_io_responder_sw_debounce.sv
// Two-flop synchronizer followed by a stable-count debouncer.
// The output follows the synced input after DEB_CYCLES mismatching cycles.
module sw_debounce #(
    parameter int DEB_CYCLES = 4
) (
    input  logic clock,
    input  logic reset,
    input  logic i_raw,
    output logic o_db
);

    localparam logic [7:0] CNT_LAST = 8'(DEB_CYCLES - 1);

    logic       r_sync1;
    logic       r_sync2;
    logic       r_db;
    logic [7:0] r_cnt;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_db    <= 1'b0;
            r_cnt   <= 8'd0;
        end else begin
            r_sync1 <= i_raw;
            r_sync2 <= r_sync1;
            if (r_sync2 == r_db) begin
                r_cnt <= 8'd0;
            end else if (r_cnt == CNT_LAST) begin
                r_db  <= r_sync2;
                r_cnt <= 8'd0;
            end else begin
                r_cnt <= r_cnt + 8'd1;
            end
        end
    end

    assign o_db = r_db;

endmodule

// File: rtl/dmem_io_responder.sv
// Data-memory responder: aliased word RAM, display, switches, countdown
// timer with sticky expiry flag. Reads are combinational, writes on clock.
module dmem_io_responder
    import dmem_io_pkg::*;
#(
    parameter int         RAM_AW     = 7,
    parameter int         DEB_CYCLES = 4,
    parameter logic [6:0] DISP_RST   = 7'h00
) (
    input  logic                clock,
    input  logic                reset,
    dmem_io_responder_if.slave  bus,
    input  logic                io_sw0,
    input  logic                io_sw1,
    output logic [6:0]          io_display,
    output logic                timer_irq
);

    localparam int RAM_DEPTH = 2 ** RAM_AW;

    logic [15:0]       r_ram [RAM_DEPTH];
    logic [6:0]        r_disp;
    logic [15:0]       r_count;
    logic              r_flag;
    logic              r_irq;

    sel_e              w_sel;
    logic [RAM_AW-1:0] w_ram_idx;
    logic              w_sw0_db;
    logic              w_sw1_db;
    logic              w_ram_we;
    logic              w_disp_we;
    logic              w_tmr_we;
    logic              w_flag_clr;
    logic              w_flag_set;
    logic [15:0]       w_count_nxt;
    logic [15:0]       w_rdata;

    assign w_sel     = addr_decode(bus.draddr);
    assign w_ram_idx = bus.draddr[RAM_AW-1:0];

    assign w_ram_we   = bus.dwrite && (w_sel == SEL_RAM);
    assign w_disp_we  = bus.dwrite && (w_sel == SEL_DISP);
    assign w_tmr_we   = bus.dwrite && (w_sel == SEL_TIMER);
    assign w_flag_clr = bus.dwrite && (w_sel == SEL_STATUS)
                        && bus.dwdata[ST_TIMER_EXP];

    sw_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_sw0 (
        .clock (clock),
        .reset (reset),
        .i_raw (io_sw0),
        .o_db  (w_sw0_db)
    );

    sw_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_sw1 (
        .clock (clock),
        .reset (reset),
        .i_raw (io_sw1),
        .o_db  (w_sw1_db)
    );

    // RAM contents survive reset; only written words are defined.
    always_ff @(posedge clock) begin
        if (w_ram_we) begin
            r_ram[w_ram_idx] <= bus.dwdata;
        end
    end

    always_comb begin
        w_count_nxt = r_count;
        w_flag_set  = 1'b0;
        if (w_tmr_we) begin
            w_count_nxt = bus.dwdata;
        end else if (r_count != 16'd0) begin
            w_count_nxt = r_count - 16'd1;
            w_flag_set  = (r_count == 16'd1);
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_disp  <= DISP_RST;
            r_count <= 16'd0;
            r_flag  <= 1'b0;
            r_irq   <= 1'b0;
        end else begin
            if (w_disp_we) begin
                r_disp <= bus.dwdata[6:0];
            end
            r_count <= w_count_nxt;
            // Expiry beats a same-cycle clear so no event is lost.
            r_flag  <= w_flag_set || (r_flag && !w_flag_clr);
            r_irq   <= r_flag;
        end
    end

    always_comb begin
        w_rdata = 16'h0000;
        if (bus.dread) begin
            unique case (w_sel)
                SEL_RAM:    w_rdata = r_ram[w_ram_idx];
                SEL_DISP:   w_rdata = {9'd0, r_disp};
                SEL_SW:     w_rdata = {14'd0, w_sw1_db, w_sw0_db};
                SEL_TIMER:  w_rdata = r_count;
                SEL_STATUS: w_rdata = {15'd0, r_flag};
                default:    w_rdata = 16'h0000;
            endcase
        end
    end

    assign bus.drdata = w_rdata;
    assign io_display = r_disp;
    assign timer_irq  = r_irq;

endmodule

// File: tb/tb_dmem_io_responder.sv
// Bench for dmem_io_responder: directed scenarios plus randomized RAM,
// display, switch-glitch and timer runs against a behavioural model.
module tb_dmem_io_responder;

    localparam int RAM_AW = 7;
    localparam int DEB    = 4;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       io_sw0 = 1'b0;
    logic       io_sw1 = 1'b0;
    logic [6:0] io_display;
    logic       timer_irq;

    int n_checks = 0;
    int n_fail   = 0;

    logic [15:0] m_ram [2**RAM_AW];
    logic [6:0]  m_disp;

    dmem_io_responder_if bus_if ();

    dmem_io_responder #(
        .RAM_AW     (RAM_AW),
        .DEB_CYCLES (DEB),
        .DISP_RST   (7'h00)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .bus        (bus_if),
        .io_sw0     (io_sw0),
        .io_sw1     (io_sw1),
        .io_display (io_display),
        .timer_irq  (timer_irq)
    );

    always #5 clock = ~clock;

    task automatic drv(input logic [15:0] a, input logic w,
                       input logic r, input logic [15:0] d);
        bus_if.draddr = a;
        bus_if.dwrite = w;
        bus_if.dread  = r;
        bus_if.dwdata = d;
        #1;
    endtask

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic wr(input logic [15:0] a, input logic [15:0] d);
        drv(a, 1'b1, 1'b0, d);
        tick();
        drv(16'h0000, 1'b0, 1'b0, 16'h0000);
    endtask

    task automatic test_reset;
        reset = 1'b0;
        drv(16'h0000, 1'b0, 1'b0, 16'h0000);
        tick();
        tick();
        n_checks++;
        if (io_display !== 7'h00 || timer_irq !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_outs disp=%h irq=%b req 00/0",
                     io_display, timer_irq);
        end
        reset = 1'b1;
        tick();
        m_disp = 7'h00;
        drv(16'h8000, 1'b0, 1'b1, 16'h0000);
        n_checks++;
        if (bus_if.drdata !== 16'h0000) begin
            n_fail++;
            $display("FAIL reset_disp got %h req 0000", bus_if.drdata);
        end
        drv(16'h8002, 1'b0, 1'b1, 16'h0000);
        n_checks++;
        if (bus_if.drdata !== 16'h0000) begin
            n_fail++;
            $display("FAIL reset_timer got %h req 0000", bus_if.drdata);
        end
        drv(16'h8003, 1'b0, 1'b1, 16'h0000);
        n_checks++;
        if (bus_if.drdata !== 16'h0000) begin
            n_fail++;
            $display("FAIL reset_status got %h req 0000", bus_if.drdata);
        end
    endtask

    task automatic test_ram;
        int          q[$];
        int          idx;
        logic [15:0] a;
        logic [15:0] d;
        wr(16'd5, 16'h1234);
        wr(16'(5 + 2**RAM_AW), 16'hBEEF);
        m_ram[5] = 16'hBEEF;
        drv(16'd5, 1'b0, 1'b1, 16'h0000);
        n_checks++;
        if (bus_if.drdata !== 16'hBEEF) begin
            n_fail++;
            $display("FAIL ram_alias got %h req BEEF", bus_if.drdata);
        end
        drv(16'd5, 1'b0, 1'b0, 16'h0000);
        n_checks++;
        if (bus_if.drdata !== 16'h0000) begin
            n_fail++;
            $display("FAIL ram_noread got %h req 0000", bus_if.drdata);
        end
        drv(16'd5, 1'b1, 1'b1, 16'h0001);
        n_checks++;
        if (bus_if.drdata !== 16'hBEEF) begin
            n_fail++;
            $display("FAIL ram_rw_same got %h req BEEF", bus_if.drdata);
        end
        tick();
        m_ram[5] = 16'h0001;
        drv(16'd5, 1'b0, 1'b1, 16'h0000);
        n_checks++;
        if (bus_if.drdata !== 16'h0001) begin
            n_fail++;
            $display("FAIL ram_rw_next got %h req 0001", bus_if.drdata);
        end
        q.push_back(5);
        for (int i = 0; i < 40; i++) begin
            idx = $urandom_range(0, 2**RAM_AW - 1);
            a = 16'($urandom_range(0, 255) * (2**RAM_AW) + idx);
            a[15] = 1'b0;
            d = 16'($urandom);
            wr(a, d);
            m_ram[idx] = d;
            q.push_back(idx);
        end
        for (int i = 0; i < 40; i++) begin
            idx = q[$urandom_range(0, q.size() - 1)];
            a = 16'($urandom_range(0, 255) * (2**RAM_AW) + idx);
            a[15] = 1'b0;
            drv(a, 1'b0, 1'b1, 16'h0000);
            n_checks++;
            if (bus_if.drdata !== m_ram[idx]) begin
                n_fail++;
                $display("FAIL ram_rand a=%h got %h req %h",
                         a, bus_if.drdata, m_ram[idx]);
            end
            tick();
        end
    endtask

    task automatic test_display;
        logic [15:0] d;
        wr(16'h8000, 16'hFF7E);
        m_disp = 7'h7E;
        n_checks++;
        if (io_display !== 7'b1111110) begin
            n_fail++;
            $display("FAIL disp_out got %b req 1111110", io_display);
        end
        drv(16'h8000, 1'b0, 1'b1, 16'h0000);
        n_checks++;
        if (bus_if.drdata !== 16'h007E) begin
            n_fail++;
            $display("FAIL disp_read got %h req 007E", bus_if.drdata);
        end
        tick();
        wr(16'h8005, 16'h1234);
        wr(16'h8001, 16'hFFFF);
        drv(16'h8005, 1'b0, 1'b1, 16'h0000);
        n_checks++;
        if (bus_if.drdata !== 16'h0000 || io_display !== m_disp) begin
            n_fail++;
            $display("FAIL disp_unmapped got %h/%h req 0000/%h",
                     bus_if.drdata, io_display, m_disp);
        end
        drv(16'h8001, 1'b0, 1'b1, 16'h0000);
        n_checks++;
        if (bus_if.drdata !== 16'h0000) begin
            n_fail++;
            $display("FAIL sw_ro got %h req 0000", bus_if.drdata);
        end
        tick();
        for (int i = 0; i < 8; i++) begin
            d = 16'($urandom);
            wr(16'h8000, d);
            m_disp = d[6:0];
            drv(16'h8000, 1'b0, 1'b1, 16'h0000);
            n_checks++;
            if (bus_if.drdata !== {9'd0, m_disp} || io_display !== m_disp) begin
                n_fail++;
                $display("FAIL disp_rand got %h/%h req %h",
                         bus_if.drdata, io_display, m_disp);
            end
            tick();
        end
    endtask

    // A pulse of L cycles on sw1 is seen at the SW register for cycles
    // 2+DEB .. L+1+DEB after it starts, and only if L >= DEB.
    task automatic test_switches;
        int          len;
        logic [15:0] exp;
        drv(16'h8001, 1'b0, 1'b1, 16'h0000);
        io_sw0 = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            tick();
            drv(16'h8001, 1'b0, 1'b1, 16'h0000);
            exp = (k >= 2 + DEB) ? 16'h0001 : 16'h0000;
            n_checks++;
            if (bus_if.drdata !== exp) begin
                n_fail++;
                $display("FAIL sw0_rise k=%0d got %h req %h",
                         k, bus_if.drdata, exp);
            end
        end
        io_sw1 = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            tick();
            if (k == 3) io_sw1 = 1'b0;
            drv(16'h8001, 1'b0, 1'b1, 16'h0000);
            n_checks++;
            if (bus_if.drdata !== 16'h0001) begin
                n_fail++;
                $display("FAIL sw1_glitch k=%0d got %h req 0001",
                         k, bus_if.drdata);
            end
        end
        io_sw0 = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            tick();
            drv(16'h8001, 1'b0, 1'b1, 16'h0000);
            exp = (k >= 2 + DEB) ? 16'h0000 : 16'h0001;
            n_checks++;
            if (bus_if.drdata !== exp) begin
                n_fail++;
                $display("FAIL sw0_fall k=%0d got %h req %h",
                         k, bus_if.drdata, exp);
            end
        end
        for (int t = 0; t < 6; t++) begin
            len = $urandom_range(1, 7);
            io_sw1 = 1'b1;
            for (int k = 1; k <= len + 8; k++) begin
                tick();
                if (k == len) io_sw1 = 1'b0;
                drv(16'h8001, 1'b0, 1'b1, 16'h0000);
                exp = (len >= DEB && k >= 2 + DEB && k < len + 2 + DEB)
                      ? 16'h0002 : 16'h0000;
                n_checks++;
                if (bus_if.drdata !== exp) begin
                    n_fail++;
                    $display("FAIL sw1_pulse len=%0d k=%0d got %h req %h",
                             len, k, bus_if.drdata, exp);
                end
            end
        end
    endtask

    // Loading N: j cycles later count = max(N-j,0), flag from j>=N,
    // irq from j>=N+1.
    task automatic test_timer;
        int          n;
        logic [15:0] ec;
        for (int t = 0; t < 5; t++) begin
            n = (t == 0) ? 3 : $urandom_range(1, 8);
            wr(16'h8002, 16'(n));
            for (int j = 1; j <= n + 2; j++) begin
                ec = (j > n) ? 16'd0 : 16'(n - j + 1);
                drv(16'h8002, 1'b0, 1'b1, 16'h0000);
                n_checks++;
                if (bus_if.drdata !== ec) begin
                    n_fail++;
                    $display("FAIL tmr_count n=%0d j=%0d got %h req %h",
                             n, j, bus_if.drdata, ec);
                end
                drv(16'h8003, 1'b0, 1'b1, 16'h0000);
                n_checks++;
                if (bus_if.drdata !== {15'd0, (j > n)}) begin
                    n_fail++;
                    $display("FAIL tmr_flag n=%0d j=%0d got %h req %0d",
                             n, j, bus_if.drdata, (j > n));
                end
                n_checks++;
                if (timer_irq !== (j > n + 1)) begin
                    n_fail++;
                    $display("FAIL tmr_irq n=%0d j=%0d got %b req %0d",
                             n, j, timer_irq, (j > n + 1));
                end
                tick();
            end
            wr(16'h8003, 16'hFFFE);
            drv(16'h8003, 1'b0, 1'b1, 16'h0000);
            n_checks++;
            if (bus_if.drdata !== 16'h0001) begin
                n_fail++;
                $display("FAIL tmr_w0 got %h req 0001", bus_if.drdata);
            end
            tick();
            wr(16'h8003, 16'h0001);
            drv(16'h8003, 1'b0, 1'b1, 16'h0000);
            n_checks++;
            if (bus_if.drdata !== 16'h0000 || timer_irq !== 1'b1) begin
                n_fail++;
                $display("FAIL tmr_w1c got %h/%b req 0000/1",
                         bus_if.drdata, timer_irq);
            end
            tick();
            n_checks++;
            if (timer_irq !== 1'b0) begin
                n_fail++;
                $display("FAIL tmr_irq_drop got %b req 0", timer_irq);
            end
        end
    endtask

    task automatic test_collisions;
        wr(16'h8002, 16'h0001);
        drv(16'h8003, 1'b1, 1'b0, 16'h0001);
        tick();
        drv(16'h8003, 1'b0, 1'b1, 16'h0000);
        n_checks++;
        if (bus_if.drdata !== 16'h0001) begin
            n_fail++;
            $display("FAIL col_set_wins got %h req 0001", bus_if.drdata);
        end
        tick();
        wr(16'h8003, 16'h0001);
        wr(16'h8002, 16'h0005);
        tick();
        wr(16'h8002, 16'h0000);
        for (int k = 0; k < 4; k++) begin
            drv(16'h8002, 1'b0, 1'b1, 16'h0000);
            n_checks++;
            if (bus_if.drdata !== 16'h0000) begin
                n_fail++;
                $display("FAIL col_stop_cnt k=%0d got %h req 0000",
                         k, bus_if.drdata);
            end
            drv(16'h8003, 1'b0, 1'b1, 16'h0000);
            n_checks++;
            if (bus_if.drdata !== 16'h0000) begin
                n_fail++;
                $display("FAIL col_stop_flag k=%0d got %h req 0000",
                         k, bus_if.drdata);
            end
            tick();
        end
        wr(16'h8002, 16'h0001);
        tick();
        tick();
        wr(16'h8002, 16'h000A);
        tick();
        tick();
        drv(16'h8002, 1'b0, 1'b1, 16'h0000);
        n_checks++;
        if (bus_if.drdata !== 16'h0008) begin
            n_fail++;
            $display("FAIL col_pre_rst got %h req 0008", bus_if.drdata);
        end
        reset = 1'b0;
        #1;
        n_checks++;
        if (bus_if.drdata !== 16'h0000) begin
            n_fail++;
            $display("FAIL col_rst_cnt got %h req 0000", bus_if.drdata);
        end
        drv(16'h8003, 1'b0, 1'b1, 16'h0000);
        n_checks++;
        if (bus_if.drdata !== 16'h0000 || timer_irq !== 1'b0
            || io_display !== 7'h00) begin
            n_fail++;
            $display("FAIL col_rst_flag got %h/%b/%h req 0000/0/00",
                     bus_if.drdata, timer_irq, io_display);
        end
        tick();
        reset = 1'b1;
        tick();
    endtask

    initial begin
        drv(16'h0000, 1'b0, 1'b0, 16'h0000);
        test_reset();
        test_ram();
        test_display();
        test_switches();
        test_timer();
        test_collisions();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
